// File: rtl/imem_loader.sv
// Instruction-memory loader: frames a UART byte stream into LE 32-bit words written to BRAM port B.
// Latency: 4th byte of a word accepted at T -> mem_we at T+1; 1 byte/cycle throughput, no stall inside DATA.
// Backpressure: rx_ready is high only while a load is in progress; optional checksum via IMEM_LOAD_CHECKSUM_EN.
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              cpu_hold,
    output logic [ADDR_W:0]   words_written
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_DONE,
        S_ERROR
`ifdef IMEM_LOAD_CHECKSUM_EN
        , S_CSUM
`endif
    } state_t;

    state_t              state_q, state_d;
    logic                rx_ready_q, busy_q, done_q, error_q, cpu_hold_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [31:0]         mem_wdata_q;
    logic [ADDR_W:0]     words_written_q;
    logic [ADDR_W:0]     len_q;
    logic [7:0]          len_lo_q;
    logic [1:0]          bcnt_q;
    logic [23:0]         wbuf_q;
`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [7:0]          sum_q;
`endif

    logic                xfer;
    logic                start_ok;
    logic [15:0]         len16;
    logic                len_bad;
    logic                last_word;
    logic                loading_d;

    // Next-state decode and transfer qualifiers.
    always_comb begin
        xfer      = rx_valid && rx_ready_q;
        start_ok  = load_start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);
        len16     = {rx_data, len_lo_q};
        len_bad   = (len16 == 16'd0) || (32'(len16) > DEPTH);
        last_word = (bcnt_q == 2'd3) && ((words_written_q + 1'b1) == len_q);
        state_d   = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: if (start_ok) state_d = S_LEN_LO;
            S_LEN_LO: if (xfer) state_d = S_LEN_HI;
            S_LEN_HI: if (xfer) state_d = len_bad ? S_ERROR : S_DATA;
            S_DATA: begin
                if (xfer && last_word) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
                    state_d = S_CSUM;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef IMEM_LOAD_CHECKSUM_EN
            S_CSUM: if (xfer) state_d = (8'(sum_q + rx_data) == 8'h00) ? S_DONE : S_ERROR;
`endif
            default: state_d = S_IDLE;
        endcase
`ifdef IMEM_LOAD_CHECKSUM_EN
        loading_d = (state_d == S_LEN_LO) || (state_d == S_LEN_HI) ||
                    (state_d == S_DATA)   || (state_d == S_CSUM);
`else
        loading_d = (state_d == S_LEN_LO) || (state_d == S_LEN_HI) || (state_d == S_DATA);
`endif
    end

    // State register with status outputs registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            cpu_hold_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_ready_q <= loading_d;
            busy_q     <= loading_d;
            done_q     <= (state_d == S_DONE);
            error_q    <= (state_d == S_ERROR);
            cpu_hold_q <= loading_d || (state_d == S_ERROR);
        end
    end

    // Datapath: length capture, word assembly, write strobe and word count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_we_q        <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            words_written_q <= '0;
            len_q           <= '0;
            len_lo_q        <= '0;
            bcnt_q          <= '0;
            wbuf_q          <= '0;
`ifdef IMEM_LOAD_CHECKSUM_EN
            sum_q           <= '0;
`endif
        end else begin
            mem_we_q <= 1'b0;
            if (start_ok) begin
                words_written_q <= '0;
                bcnt_q          <= '0;
`ifdef IMEM_LOAD_CHECKSUM_EN
                sum_q           <= '0;
`endif
            end
            if (xfer) begin
                case (state_q)
                    S_LEN_LO: len_lo_q <= rx_data;
                    S_LEN_HI: len_q    <= len16[ADDR_W:0];
                    S_DATA: begin
`ifdef IMEM_LOAD_CHECKSUM_EN
                        sum_q <= sum_q + rx_data;
`endif
                        bcnt_q <= bcnt_q + 2'd1;
                        if (bcnt_q == 2'd3) begin
                            // Word index doubles as the write address; the length check keeps it in range.
                            mem_wdata_q     <= {rx_data, wbuf_q};
                            mem_addr_q      <= words_written_q[ADDR_W-1:0];
                            mem_we_q        <= 1'b1;
                            words_written_q <= words_written_q + 1'b1;
                        end else begin
                            wbuf_q[8*bcnt_q +: 8] <= rx_data;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rx_ready      = rx_ready_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign cpu_hold      = cpu_hold_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign words_written = words_written_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framing, length limits, gaps, reset mid-load, optional checksum.
module tb_imem_loader;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              load_start;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              busy;
    logic              done;
    logic              error;
    logic              cpu_hold;
    logic [ADDR_W:0]   words_written;

    int                checks = 0;
    int                errors = 0;
    int                wr_cnt = 0;
    logic [ADDR_W-1:0] wr_addr [256];
    logic [31:0]       wr_data [256];
    logic [7:0]        psum;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .load_start(load_start),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .error(error), .cpu_hold(cpu_hold),
        .words_written(words_written)
    );

    always #5 clk = ~clk;

    // Write monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (wr_cnt < 256) begin
                wr_addr[wr_cnt] = mem_addr;
                wr_data[wr_cnt] = mem_wdata;
            end
            wr_cnt = wr_cnt + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic xfer(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        psum = psum + b;
        xfer(b);
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[7:0]);
        send_byte(w[15:8]);
        send_byte(w[23:16]);
        send_byte(w[31:24]);
    endtask

    task automatic start();
        load_start = 1'b1;
        @(posedge clk);
        #1;
        load_start = 1'b0;
        psum   = 8'h00;
        wr_cnt = 0;
    endtask

    task automatic finish_frame();
`ifdef IMEM_LOAD_CHECKSUM_EN
        xfer(8'(8'h00 - psum));
`endif
    endtask

    function automatic logic [31:0] full_word(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {8'(b + 8'd1), 8'h3C, ~b, b};
    endfunction

    task automatic test_reset();
        checks++;
        if ({rx_ready, mem_we, busy, done, error, cpu_hold} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 000000", {rx_ready, mem_we, busy, done, error, cpu_hold});
        end
        checks++;
        if (mem_addr !== '0 || mem_wdata !== '0 || words_written !== '0) begin
            errors++;
            $display("FAIL reset_data addr %h wdata %h ww %0d exp all 0", mem_addr, mem_wdata, words_written);
        end
    endtask

    task automatic test_single();
        start();
        checks++;
        if ({rx_ready, busy, cpu_hold, done} !== 4'b1110) begin
            errors++;
            $display("FAIL single_start rdy/busy/hold/done got %b exp 1110", {rx_ready, busy, cpu_hold, done});
        end
        xfer(8'h01);
        xfer(8'h00);
        send_byte(8'h13);
        send_byte(8'h00);
        send_byte(8'h00);
        checks++;
        if (mem_we !== 1'b0) begin
            errors++;
            $display("FAIL single_early_we got %b exp 0", mem_we);
        end
        send_byte(8'h00);
`ifdef IMEM_LOAD_CHECKSUM_EN
        checks++;
        if ({mem_we, done, rx_ready} !== 3'b101) begin
            errors++;
            $display("FAIL single_we_csum we/done/rdy got %b exp 101", {mem_we, done, rx_ready});
        end
        finish_frame();
        checks++;
        if ({done, cpu_hold} !== 2'b10) begin
            errors++;
            $display("FAIL single_done_csum done/hold got %b exp 10", {done, cpu_hold});
        end
`else
        checks++;
        if ({mem_we, done, cpu_hold, rx_ready, busy} !== 5'b11000) begin
            errors++;
            $display("FAIL single_done we/done/hold/rdy/busy got %b exp 11000", {mem_we, done, cpu_hold, rx_ready, busy});
        end
        checks++;
        if (mem_addr !== 8'h00 || mem_wdata !== 32'h0000_0013 || words_written !== 9'd1) begin
            errors++;
            $display("FAIL single_write addr %h data %h ww %0d exp 00 00000013 1", mem_addr, mem_wdata, words_written);
        end
`endif
        tick(3);
        checks++;
        if (wr_cnt !== 1) begin
            errors++;
            $display("FAIL single_wr_cnt got %0d exp 1", wr_cnt);
        end
    endtask

    task automatic test_gaps();
        logic [7:0] bytes [8];
        int k;
        bytes = '{8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h20, 8'h00};
        start();
        xfer(8'h02);
        tick(2);
        xfer(8'h00);
        for (int i = 0; i < 8; i++) begin
            k = $urandom_range(0, 2);
            if (k > 0) tick(k);
            send_byte(bytes[i]);
        end
        finish_frame();
        tick(3);
        checks++;
        if (wr_cnt !== 2) begin
            errors++;
            $display("FAIL gaps_wr_cnt got %0d exp 2", wr_cnt);
        end
        checks++;
        if (wr_addr[0] !== 8'h00 || wr_data[0] !== 32'h0010_0093) begin
            errors++;
            $display("FAIL gaps_w0 addr %h data %h exp 00 00100093", wr_addr[0], wr_data[0]);
        end
        checks++;
        if (wr_addr[1] !== 8'h01 || wr_data[1] !== 32'h0020_0113) begin
            errors++;
            $display("FAIL gaps_w1 addr %h data %h exp 01 00200113", wr_addr[1], wr_data[1]);
        end
        checks++;
        if (done !== 1'b1 || words_written !== 9'd2) begin
            errors++;
            $display("FAIL gaps_done done %b ww %0d exp 1 2", done, words_written);
        end
    endtask

    task automatic test_len_errors();
        start();
        xfer(8'h00);
        xfer(8'h00);
        checks++;
        if ({error, cpu_hold, busy, rx_ready, done} !== 5'b11000) begin
            errors++;
            $display("FAIL len0 err/hold/busy/rdy/done got %b exp 11000", {error, cpu_hold, busy, rx_ready, done});
        end
        tick(2);
        checks++;
        if (wr_cnt !== 0) begin
            errors++;
            $display("FAIL len0_writes got %0d exp 0", wr_cnt);
        end
        start();
        checks++;
        if ({error, busy, rx_ready} !== 3'b011) begin
            errors++;
            $display("FAIL len0_restart err/busy/rdy got %b exp 011", {error, busy, rx_ready});
        end
        // A start pulse while busy must not disturb the frame in progress.
        load_start = 1'b1;
        tick(1);
        load_start = 1'b0;
        xfer(8'h01);
        xfer(8'h01);
        checks++;
        if ({error, cpu_hold, busy} !== 3'b110) begin
            errors++;
            $display("FAIL len257 err/hold/busy got %b exp 110", {error, cpu_hold, busy});
        end
        tick(2);
        checks++;
        if (wr_cnt !== 0 || words_written !== 9'd0) begin
            errors++;
            $display("FAIL len257_writes got %0d ww %0d exp 0 0", wr_cnt, words_written);
        end
    endtask

    task automatic test_full();
        int bad;
        start();
        xfer(8'h00);
        xfer(8'h01);
        for (int i = 0; i < 256; i++) begin
            send_word(full_word(i));
            if (i == 254) begin
                checks++;
                if ({done, busy} !== 2'b01) begin
                    errors++;
                    $display("FAIL full_not_done done/busy got %b exp 01", {done, busy});
                end
            end
        end
`ifndef IMEM_LOAD_CHECKSUM_EN
        checks++;
        if ({mem_we, done, cpu_hold} !== 3'b110 || mem_addr !== 8'hFF) begin
            errors++;
            $display("FAIL full_last we/done/hold %b addr %h exp 110 ff", {mem_we, done, cpu_hold}, mem_addr);
        end
`endif
        finish_frame();
        tick(3);
        checks++;
        if (wr_cnt !== 256) begin
            errors++;
            $display("FAIL full_wr_cnt got %0d exp 256", wr_cnt);
        end
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (wr_addr[i] !== 8'(i) || wr_data[i] !== full_word(i)) begin
                if (bad < 4)
                    $display("FAIL full_word_%0d addr %h data %h exp %h %h", i, wr_addr[i], wr_data[i], 8'(i), full_word(i));
                bad++;
            end
        end
        checks++;
        if (bad != 0) errors++;
        checks++;
        if (done !== 1'b1 || words_written !== 9'h100) begin
            errors++;
            $display("FAIL full_done done %b ww %0d exp 1 256", done, words_written);
        end
    endtask

    task automatic test_reset_mid();
        start();
        xfer(8'h01);
        xfer(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        rst = 1'b1;
        #2;
        checks++;
        if ({rx_ready, mem_we, busy, done, error, cpu_hold} !== 6'b0) begin
            errors++;
            $display("FAIL rstmid_ctrl got %b exp 000000", {rx_ready, mem_we, busy, done, error, cpu_hold});
        end
        checks++;
        if (mem_addr !== '0 || mem_wdata !== '0 || words_written !== '0) begin
            errors++;
            $display("FAIL rstmid_data addr %h wdata %h ww %0d exp all 0", mem_addr, mem_wdata, words_written);
        end
        tick(1);
        rst = 1'b0;
        tick(2);
        checks++;
        if (wr_cnt !== 0) begin
            errors++;
            $display("FAIL rstmid_writes got %0d exp 0", wr_cnt);
        end
        start();
        xfer(8'h01);
        xfer(8'h00);
        send_word(32'hDEAD_BEEF);
        finish_frame();
        tick(3);
        checks++;
        if (wr_cnt !== 1 || wr_addr[0] !== 8'h00 || wr_data[0] !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL rstmid_reload cnt %0d addr %h data %h exp 1 00 deadbeef", wr_cnt, wr_addr[0], wr_data[0]);
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_done got %b exp 1", done);
        end
    endtask

`ifdef IMEM_LOAD_CHECKSUM_EN
    task automatic test_checksum();
        start();
        xfer(8'h01);
        xfer(8'h00);
        send_word(32'h0000_0013);
        xfer(8'hED);
        checks++;
        if ({done, error, cpu_hold} !== 3'b100) begin
            errors++;
            $display("FAIL csum_ok done/err/hold got %b exp 100", {done, error, cpu_hold});
        end
        start();
        xfer(8'h01);
        xfer(8'h00);
        send_word(32'h0000_0013);
        xfer(8'hEE);
        checks++;
        if ({done, error, cpu_hold} !== 3'b011) begin
            errors++;
            $display("FAIL csum_bad done/err/hold got %b exp 011", {done, error, cpu_hold});
        end
        tick(2);
        checks++;
        if (wr_cnt !== 1 || wr_data[0] !== 32'h0000_0013) begin
            errors++;
            $display("FAIL csum_bad_write cnt %0d data %h exp 1 00000013", wr_cnt, wr_data[0]);
        end
    endtask
`endif

    initial begin
        rst        = 1'b1;
        load_start = 1'b0;
        rx_valid   = 1'b0;
        rx_data    = 8'h00;
        psum       = 8'h00;
        tick(2);
        test_reset();
        rst = 1'b0;
        tick(2);
        test_single();
        test_gaps();
        test_len_errors();
        test_full();
        test_reset_mid();
`ifdef IMEM_LOAD_CHECKSUM_EN
        test_checksum();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
